// File: rtl/i2c_cmd_sequencer.sv
// ============================================================================
// i2c_cmd_sequencer
//
// Frame-level controller of the UART-to-I2C bridge. It parses host command
// frames arriving on the UART RX byte stream, drives START / address / data /
// STOP operations into the I2C byte engine, and returns read data followed by
// one status byte per frame on the UART TX byte stream.
//
// Frame:  byte0 = {addr[6:0], rw}   (rw = 1 : read)
//         byte1 = N                 (0..255, N = 0 is an address probe)
//         write frames carry N further data bytes
// Status: 0x00 OK, 0x01 address NACK, 0x02 data NACK, 0x03 engine error,
//         0x04 host timeout
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready       host bytes from the UART receiver
//   tx_data/tx_valid/tx_ready       reply bytes to the UART transmitter
//   cmd_op/cmd_wdata/cmd_valid/cmd_ready
//                                   op request to the byte engine
//                                   (0 START, 1 STOP, 2 WRITE, 3 READ_ACK,
//                                    4 READ_NACK)
//   resp_valid/resp_rdata/resp_nack/resp_err
//                                   completion pulse of the outstanding op
//   busy                            high whenever a frame is in progress
// ============================================================================
module i2c_cmd_sequencer #(
    parameter int RX_TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_wdata,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    input  logic       resp_valid,
    input  logic [7:0] resp_rdata,
    input  logic       resp_nack,
    input  logic       resp_err,
    output logic       busy
);

    localparam int TW = $clog2(RX_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(RX_TIMEOUT_CYCLES);

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_STOP      = 3'd1;
    localparam logic [2:0] OP_WRITE     = 3'd2;
    localparam logic [2:0] OP_READ_ACK  = 3'd3;
    localparam logic [2:0] OP_READ_NACK = 3'd4;

    localparam logic [7:0] STS_OK    = 8'h00;
    localparam logic [7:0] STS_ANACK = 8'h01;
    localparam logic [7:0] STS_DNACK = 8'h02;
    localparam logic [7:0] STS_ERR   = 8'h03;
    localparam logic [7:0] STS_TMO   = 8'h04;

    typedef enum logic [3:0] {
        IDLE,
        GET_LEN,
        DO_START,
        DO_ADDR,
        GET_WBYTE,
        DO_WRITE,
        DO_READ,
        SEND_RBYTE,
        DRAIN,
        DO_STOP,
        SEND_STATUS
    } state_t;

    state_t          state,      state_nxt;
    logic [7:0]      addr_byte,  addr_byte_nxt;
    logic [7:0]      wbyte,      wbyte_nxt;
    logic [7:0]      remaining,  remaining_nxt;
    logic [7:0]      status,     status_nxt;
    logic            pending,    pending_nxt;
    logic [TW-1:0]   tmo_cnt,    tmo_cnt_nxt;
    logic            rx_ready_nxt;
    logic            tx_valid_nxt;
    logic [7:0]      tx_data_nxt;
    logic            cmd_valid_nxt;
    logic [2:0]      cmd_op_nxt;
    logic [7:0]      cmd_wdata_nxt;
    logic            busy_nxt;

    logic            rx_fire;
    logic            resp_fire;
    logic            tmo_hit;
    logic            wr_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_byte <= 8'h00;
            wbyte     <= 8'h00;
            remaining <= 8'h00;
            status    <= STS_OK;
            pending   <= 1'b0;
            tmo_cnt   <= '0;
            rx_ready  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_START;
            cmd_wdata <= 8'h00;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_byte <= addr_byte_nxt;
            wbyte     <= wbyte_nxt;
            remaining <= remaining_nxt;
            status    <= status_nxt;
            pending   <= pending_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            rx_ready  <= rx_ready_nxt;
            tx_valid  <= tx_valid_nxt;
            tx_data   <= tx_data_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd_op    <= cmd_op_nxt;
            cmd_wdata <= cmd_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_byte_nxt = addr_byte;
        wbyte_nxt     = wbyte;
        remaining_nxt = remaining;
        status_nxt    = status;
        pending_nxt   = pending;
        tx_valid_nxt  = tx_valid;
        tx_data_nxt   = tx_data;
        cmd_valid_nxt = cmd_valid;
        cmd_op_nxt    = cmd_op;
        cmd_wdata_nxt = cmd_wdata;
        resp_fire     = 1'b0;
        rx_fire       = rx_valid && rx_ready;
        tmo_hit       = (tmo_cnt == TMO_MAX);
        // host still owes data bytes of a write frame
        wr_left       = !addr_byte[0] && (remaining != 8'h00);

        // Shared op handshake for every DO_* state: raise the request one
        // cycle after entry, drop it on acceptance, then wait for the single
        // completion pulse. Responses with nothing outstanding fall through.
        if (state inside {DO_START, DO_ADDR, DO_WRITE, DO_READ, DO_STOP}) begin
            if (!cmd_valid && !pending) begin
                cmd_valid_nxt = 1'b1;
                case (state)
                    DO_START: cmd_op_nxt = OP_START;
                    DO_ADDR: begin
                        cmd_op_nxt    = OP_WRITE;
                        cmd_wdata_nxt = addr_byte;
                    end
                    DO_WRITE: begin
                        cmd_op_nxt    = OP_WRITE;
                        cmd_wdata_nxt = wbyte;
                    end
                    DO_READ:  cmd_op_nxt = (remaining == 8'h01) ? OP_READ_NACK : OP_READ_ACK;
                    default:  cmd_op_nxt = OP_STOP;
                endcase
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid_nxt = 1'b0;
                pending_nxt   = 1'b1;
            end else if (pending && resp_valid) begin
                pending_nxt = 1'b0;
                resp_fire   = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (rx_fire) begin
                    addr_byte_nxt = rx_data;
                    status_nxt    = STS_OK;
                    state_nxt     = GET_LEN;
                end
            end
            GET_LEN: begin
                if (rx_fire) begin
                    remaining_nxt = rx_data;
                    state_nxt     = DO_START;
                end else if (tmo_hit) begin
                    status_nxt = STS_TMO;
                    state_nxt  = SEND_STATUS;
                end
            end
            DO_START: begin
                if (resp_fire) begin
                    if (resp_err) begin
                        status_nxt = STS_ERR;
                        state_nxt  = wr_left ? DRAIN : SEND_STATUS;
                    end else begin
                        state_nxt = DO_ADDR;
                    end
                end
            end
            DO_ADDR: begin
                if (resp_fire) begin
                    if (resp_err) begin
                        status_nxt = STS_ERR;
                        state_nxt  = wr_left ? DRAIN : SEND_STATUS;
                    end else if (resp_nack) begin
                        status_nxt = STS_ANACK;
                        state_nxt  = wr_left ? DRAIN : DO_STOP;
                    end else if (remaining == 8'h00) begin
                        state_nxt = DO_STOP;
                    end else begin
                        state_nxt = addr_byte[0] ? DO_READ : GET_WBYTE;
                    end
                end
            end
            GET_WBYTE: begin
                if (rx_fire) begin
                    wbyte_nxt     = rx_data;
                    remaining_nxt = remaining - 8'd1;
                    state_nxt     = DO_WRITE;
                end else if (tmo_hit) begin
                    status_nxt = STS_TMO;
                    state_nxt  = DO_STOP;
                end
            end
            DO_WRITE: begin
                if (resp_fire) begin
                    if (resp_err) begin
                        status_nxt = STS_ERR;
                        state_nxt  = wr_left ? DRAIN : SEND_STATUS;
                    end else if (resp_nack) begin
                        status_nxt = STS_DNACK;
                        state_nxt  = wr_left ? DRAIN : DO_STOP;
                    end else begin
                        state_nxt = (remaining == 8'h00) ? DO_STOP : GET_WBYTE;
                    end
                end
            end
            DO_READ: begin
                if (resp_fire) begin
                    if (resp_err) begin
                        status_nxt = STS_ERR;
                        state_nxt  = SEND_STATUS;
                    end else begin
                        tx_data_nxt   = resp_rdata;
                        tx_valid_nxt  = 1'b1;
                        remaining_nxt = remaining - 8'd1;
                        state_nxt     = SEND_RBYTE;
                    end
                end
            end
            SEND_RBYTE: begin
                // next READ waits for the host side to take this byte
                if (tx_valid && tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = (remaining == 8'h00) ? DO_STOP : DO_READ;
                end
            end
            DRAIN: begin
                if (rx_fire) begin
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'h01) begin
                        state_nxt = (status == STS_ERR) ? SEND_STATUS : DO_STOP;
                    end
                end else if (tmo_hit) begin
                    // engine error already released the bus: no STOP then
                    state_nxt = (status == STS_ERR) ? SEND_STATUS : DO_STOP;
                end
            end
            DO_STOP: begin
                if (resp_fire) begin
                    if (resp_err) begin
                        status_nxt = STS_ERR;
                    end
                    state_nxt = SEND_STATUS;
                end
            end
            SEND_STATUS: begin
                if (tx_valid && tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // status byte is presented on the cycle after the deciding event
        if ((state_nxt == SEND_STATUS) && (state != SEND_STATUS)) begin
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = status_nxt;
        end

        rx_ready_nxt = state_nxt inside {IDLE, GET_LEN, GET_WBYTE, DRAIN};
        busy_nxt     = (state_nxt != IDLE);

        // host inter-byte timer: restarts on every accepted byte and on entry
        if ((state inside {GET_LEN, GET_WBYTE, DRAIN}) && (state_nxt == state) && !rx_fire) begin
            tmo_cnt_nxt = tmo_cnt + TW'(1);
        end else begin
            tmo_cnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
module tb_i2c_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_nack;
    logic       resp_err;
    logic       busy;

    i2c_cmd_sequencer #(.RX_TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .cmd_op     (cmd_op),
        .cmd_wdata  (cmd_wdata),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_nack  (resp_nack),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // engine log, tx log and expectations
    logic [2:0] lop[$];
    logic [7:0] lwd[$];
    logic [7:0] ltx[$];
    logic [2:0] eop[$];
    logic [7:0] ewd[$];
    logic [7:0] etx[$];
    logic [7:0] rdq[$];

    int nack_at = -1;
    int err_at  = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // byte engine model: inputs driven / outputs sampled 1 unit after negedge
    initial begin
        int delay;
        int idx;
        bit is_rd;
        delay = 0;
        idx = 0;
        is_rd = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 8'h00;
        resp_nack  = 1'b0;
        resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            resp_valid = 1'b0;
            resp_nack  = 1'b0;
            resp_err   = 1'b0;
            if (!rst_n) begin
                delay = 0;
            end else if (delay > 0) begin
                delay--;
                if (delay == 0) begin
                    resp_valid = 1'b1;
                    resp_nack  = (idx == nack_at);
                    resp_err   = (idx == err_at);
                    resp_rdata = 8'h00;
                    if (is_rd && rdq.size() > 0) resp_rdata = rdq.pop_front();
                end
            end else if (cmd_valid && cmd_ready) begin
                lop.push_back(cmd_op);
                lwd.push_back(cmd_wdata);
                idx   = lop.size() - 1;
                is_rd = (cmd_op == 3'd3) || (cmd_op == 3'd4);
                delay = 2;
            end
        end
    end

    // UART TX sink
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && tx_valid && tx_ready) ltx.push_back(tx_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        while (!rx_ready && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("rx_accept_%02h", b), 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int rdy_cycles);
        int n;
        n = 0;
        rdy_cycles = 0;
        #1;
        while (busy && n < 3000) begin
            @(negedge clk);
            #1;
            if (rx_ready) rdy_cycles++;
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic exp_op(input logic [2:0] op, input logic [7:0] wd);
        eop.push_back(op);
        ewd.push_back(wd);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_nops"}, 32'(lop.size()), 32'(eop.size()));
        for (int i = 0; i < eop.size() && i < lop.size(); i++) begin
            check($sformatf("%s_op%0d", tag, i), 32'(lop[i]), 32'(eop[i]));
            if (eop[i] == 3'd2) check($sformatf("%s_wd%0d", tag, i), 32'(lwd[i]), 32'(ewd[i]));
        end
        check({tag, "_ntx"}, 32'(ltx.size()), 32'(etx.size()));
        for (int i = 0; i < etx.size() && i < ltx.size(); i++) begin
            check($sformatf("%s_tx%0d", tag, i), 32'(ltx[i]), 32'(etx[i]));
        end
        lop.delete(); lwd.delete(); ltx.delete();
        eop.delete(); ewd.delete(); etx.delete(); rdq.delete();
        nack_at = -1;
        err_at  = -1;
    endtask

    initial begin
        int rc;
        int n;
        int unstable;
        logic [7:0] held;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        cmd_ready = 1'b1;
        rst_n     = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rx_ready",  32'(rx_ready),  32'd0);
        check("rst_tx_valid",  32'(tx_valid),  32'd0);
        check("rst_tx_data",   32'(tx_data),   32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_op",    32'(cmd_op),    32'd0);
        check("rst_cmd_wdata", 32'(cmd_wdata), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // write two bytes, all ACK
        send_byte(8'hA0); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        wait_idle("wr", rc);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'hA0); exp_op(3'd2, 8'h11);
        exp_op(3'd2, 8'h22); exp_op(3'd1, 8'h00);
        etx.push_back(8'h00);
        check_frame("wr");

        // read three bytes
        rdq.push_back(8'h5A); rdq.push_back(8'h5B); rdq.push_back(8'h5C);
        send_byte(8'hA1); send_byte(8'h03);
        wait_idle("rd", rc);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'hA1); exp_op(3'd3, 8'h00);
        exp_op(3'd3, 8'h00); exp_op(3'd4, 8'h00); exp_op(3'd1, 8'h00);
        etx.push_back(8'h5A); etx.push_back(8'h5B); etx.push_back(8'h5C); etx.push_back(8'h00);
        check_frame("rd");

        // address NACK on a write: data bytes drained, STOP, status 0x01
        nack_at = 1;
        send_byte(8'h90); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        wait_idle("anack", rc);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'h90); exp_op(3'd1, 8'h00);
        etx.push_back(8'h01);
        check_frame("anack");

        // following frame: address probe N=0
        send_byte(8'h50); send_byte(8'h00);
        wait_idle("probe", rc);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'h50); exp_op(3'd1, 8'h00);
        etx.push_back(8'h00);
        check_frame("probe");

        // data NACK on first data byte: rest drained, STOP, status 0x02
        nack_at = 2;
        send_byte(8'hA0); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        wait_idle("dnack", rc);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'hA0); exp_op(3'd2, 8'h01); exp_op(3'd1, 8'h00);
        etx.push_back(8'h02);
        check_frame("dnack");

        // host silent after N: rx_ready stays up through the 100-cycle window
        // (entry cycle plus 100 counted cycles, one cycle of slack either side)
        send_byte(8'hA0); send_byte(8'h01);
        wait_idle("tmo", rc);
        check("tmo_window_ge", 32'(rc >= 100), 32'd1);
        check("tmo_window_le", 32'(rc <= 102), 32'd1);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'hA0); exp_op(3'd1, 8'h00);
        etx.push_back(8'h04);
        check_frame("tmo");

        // engine error on second read byte, host TX stalled 20 cycles
        rdq.push_back(8'h77); rdq.push_back(8'h88);
        err_at = 3;
        tx_ready = 1'b0;
        send_byte(8'hA1); send_byte(8'h02);
        n = 0;
        #1;
        while (!tx_valid && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("err_first_valid", 32'(tx_valid), 32'd1);
        held = tx_data;
        check("err_first_data", 32'(held), 32'h77);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (!tx_valid || tx_data != held) unstable++;
            if (lop.size() != 3) unstable++;
        end
        check("err_hold_stable", 32'(unstable), 32'd0);
        @(negedge clk);
        tx_ready = 1'b1;
        wait_idle("err", rc);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'hA1); exp_op(3'd3, 8'h00); exp_op(3'd4, 8'h00);
        etx.push_back(8'h77); etx.push_back(8'h03);
        check_frame("err");

        // reset while a request is pending on the engine
        cmd_ready = 1'b0;
        send_byte(8'hA0); send_byte(8'h00);
        n = 0;
        #1;
        while (!cmd_valid && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_cmd_valid", 32'(cmd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("arst_tx_valid",  32'(tx_valid),  32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        lop.delete(); lwd.delete(); ltx.delete();
        send_byte(8'hA0); send_byte(8'h01); send_byte(8'h55);
        wait_idle("post", rc);
        exp_op(3'd0, 8'h00); exp_op(3'd2, 8'hA0); exp_op(3'd2, 8'h55); exp_op(3'd1, 8'h00);
        etx.push_back(8'h00);
        check_frame("post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
